// File: rtl/note_disp_pkg.sv
// ---------------------------------------------------------------------------
// note_disp_pkg
// Shared definitions for the note display sequencer:
//   - disp_state_e : sequencer FSM state encoding
//   - NOTE_A..NOTE_GS : note codes delivered by the tone front end (1..12)
//   - default VGA canvas / glyph geometry
//   - note_code_valid() : true for codes that map to a drawable glyph
// ---------------------------------------------------------------------------
package note_disp_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DRAW  = 2'd3
    } disp_state_e;

    localparam logic [3:0] NOTE_A  = 4'd1;
    localparam logic [3:0] NOTE_AS = 4'd2;
    localparam logic [3:0] NOTE_B  = 4'd3;
    localparam logic [3:0] NOTE_C  = 4'd4;
    localparam logic [3:0] NOTE_CS = 4'd5;
    localparam logic [3:0] NOTE_D  = 4'd6;
    localparam logic [3:0] NOTE_DS = 4'd7;
    localparam logic [3:0] NOTE_E  = 4'd8;
    localparam logic [3:0] NOTE_F  = 4'd9;
    localparam logic [3:0] NOTE_FS = 4'd10;
    localparam logic [3:0] NOTE_G  = 4'd11;
    localparam logic [3:0] NOTE_GS = 4'd12;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int GLYPH_SIZE = 12;

    // One buffered event is {octave[1:0], note[3:0]}.
    localparam int EVENT_W = 6;

    function automatic logic note_code_valid(input logic [3:0] code);
        return (code >= NOTE_A) && (code <= NOTE_GS);
    endfunction

endpackage

// File: rtl/note_fifo.sv
// ---------------------------------------------------------------------------
// note_fifo
// Small synchronous FIFO buffering note events ahead of the sequencer.
// Show-ahead read: dout always presents the head entry while not empty.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (empties FIFO)
//   push, din        : write request / data (ignored while full)
//   pop              : remove head (ignored while empty)
//   dout             : head entry
//   full, empty      : occupancy flags
// Simultaneous push and pop are both performed; occupancy is unchanged.
// ---------------------------------------------------------------------------
module note_fifo
    import note_disp_pkg::*;
#(
    parameter int WIDTH      = EVENT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign full      = (count_r == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count_r == '0);
    assign dout      = mem_r[rd_ptr_r];

    // Storage array and write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
        end
    end

    // Read pointer and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/note_display_ctrl.sv
// ---------------------------------------------------------------------------
// note_display_ctrl
// Sequencer in front of the note glyph drawer. Buffers note events, assigns
// each a cell on the 160x120 canvas, and holds the drawer's inputs for its
// fixed frame counts. Sequences full-screen clears at reset, on request and
// (optionally) when the cell grid fills.
// Configuration macro: NOTE_DISP_AUTOCLEAR_EN -- when defined, a full grid
// forces a clear after its last draw; otherwise the cursor simply wraps.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   note_in, octave_in         : event payload (codes 0, 13..15 are dropped)
//   note_valid / note_ready    : event handshake (ready = FIFO not full)
//   clear_req                  : one-cycle screen wipe request
//   note_out, octave_out, x, y : drawer glyph selection and cell origin
//   ld_note                    : drawer enable for the whole draw window
//   clear_n                    : drawer clear, active-low
//   busy                       : sequencer not idle
// ---------------------------------------------------------------------------
module note_display_ctrl
    import note_disp_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int X0           = 2,
    parameter int Y0           = 2,
    parameter int CELL_W       = 40,
    parameter int CELL_H       = 16,
    parameter int COLS         = 4,
    parameter int ROWS         = 7,
    parameter int DRAW_CYCLES  = 432,
    parameter int CLEAR_CYCLES = 19200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic       clear_req,
    output logic [3:0] note_out,
    output logic [1:0] octave_out,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       ld_note,
    output logic       clear_n,
    output logic       busy
);

`ifdef NOTE_DISP_AUTOCLEAR_EN
    localparam logic AUTOCLEAR_EN = 1'b1;
`else
    localparam logic AUTOCLEAR_EN = 1'b0;
`endif

    localparam int CNT_MAX = (CLEAR_CYCLES > DRAW_CYCLES) ? CLEAR_CYCLES : DRAW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAW_LAST = CNT_W'(DRAW_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

    disp_state_e          state_r;
    disp_state_e          state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [COL_W-1:0]     col_r;
    logic [ROW_W-1:0]     row_r;
    logic                 clear_pending_r;
    logic [3:0]           note_out_r;
    logic [1:0]           octave_out_r;
    logic [7:0]           x_r;
    logic [6:0]           y_r;
    logic                 ld_note_r;
    logic                 clear_n_r;
    logic                 busy_r;

    logic                 fifo_push_s;
    logic                 fifo_pop_s;
    logic [EVENT_W-1:0]   fifo_dout_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 draw_done_s;
    logic                 grid_full_s;

    // Invalid codes complete the handshake but are never buffered.
    assign fifo_push_s = note_valid && !fifo_full_s && note_code_valid(note_in);
    assign fifo_pop_s  = (state_r == ST_LOAD);
    assign draw_done_s = (state_r == ST_DRAW) && (cnt_r == DRAW_LAST);
    assign grid_full_s = (col_r == COL_LAST) && (row_r == ROW_LAST);

    note_fifo #(
        .WIDTH      (EVENT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   ({octave_in, note_in}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state and cycle-counter logic; the counter restarts on every entry.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == CLR_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                cnt_nxt_s = '0;
                if (clear_pending_r || clear_req) begin
                    state_nxt_s = ST_CLEAR;
                end else if (!fifo_empty_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_DRAW;
                cnt_nxt_s   = '0;
            end
            ST_DRAW: begin
                if (cnt_r == DRAW_LAST) begin
                    cnt_nxt_s = '0;
                    // A clear requested during LOAD/DRAW goes straight in once the glyph is done.
                    if (clear_pending_r || clear_req || (grid_full_s && AUTOCLEAR_EN)) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_DRAW;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State register and state-decoded drawer controls, registered off next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            cnt_r     <= '0;
            clear_n_r <= 1'b0;
            ld_note_r <= 1'b0;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            clear_n_r <= (state_nxt_s != ST_CLEAR);
            ld_note_r <= (state_nxt_s == ST_DRAW);
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    // Deferred clear flag: remembers a clear_req that arrives mid-draw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_pending_r <= 1'b0;
        end else if (state_r == ST_CLEAR) begin
            clear_pending_r <= 1'b0;
        end else if (clear_req && ((state_r == ST_LOAD) || (state_r == ST_DRAW))) begin
            clear_pending_r <= 1'b1;
        end
    end

    // Cell cursor: reset by any clear, advanced row-major after each glyph.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
        end else if (state_r == ST_CLEAR) begin
            col_r <= '0;
            row_r <= '0;
        end else if (draw_done_s) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                row_r <= (row_r == ROW_LAST) ? '0 : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Drawer payload captured in LOAD and held until the next LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_out_r   <= 4'd0;
            octave_out_r <= 2'd0;
            x_r          <= 8'(X0);
            y_r          <= 7'(Y0);
        end else if (state_r == ST_LOAD) begin
            note_out_r   <= fifo_dout_s[3:0];
            octave_out_r <= fifo_dout_s[5:4];
            x_r          <= 8'(X0 + CELL_W * int'(col_r));
            y_r          <= 7'(Y0 + CELL_H * int'(row_r));
        end
    end

    assign note_ready = !fifo_full_s;
    assign note_out   = note_out_r;
    assign octave_out = octave_out_r;
    assign x          = x_r;
    assign y          = y_r;
    assign ld_note    = ld_note_r;
    assign clear_n    = clear_n_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_note_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_note_display_ctrl
// Directed self-checking bench for note_display_ctrl with default parameters.
// A negedge monitor records every ld_note window (payload, length, stability);
// expected cells come from a small row-major cursor model.
// ---------------------------------------------------------------------------
module tb_note_display_ctrl;

`ifdef NOTE_DISP_AUTOCLEAR_EN
    localparam int EXP_AUTO_CLR = 1;
`else
    localparam int EXP_AUTO_CLR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       note_valid;
    logic       note_ready;
    logic       clear_req;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic [7:0] x;
    logic [6:0] y;
    logic       ld_note;
    logic       clear_n;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // monitor state
    int rec_note[$], rec_oct[$], rec_x[$], rec_y[$], rec_len[$], rec_stable[$];
    int exp_note[$], exp_oct[$], exp_x[$], exp_y[$];
    bit in_draw = 1'b0;
    int cap_n, cap_o, cap_x, cap_y, cap_len, cap_stable;
    int clr_falls = 0;
    bit clear_prev = 1'b0;
    int cell_idx = 0;

    note_display_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .note_in    (note_in),
        .octave_in  (octave_in),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .clear_req  (clear_req),
        .note_out   (note_out),
        .octave_out (octave_out),
        .x          (x),
        .y          (y),
        .ld_note    (ld_note),
        .clear_n    (clear_n),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Draw-window recorder.
    always @(negedge clk) begin
        if (reset) begin
            in_draw = 1'b0;
        end else if (ld_note) begin
            if (!in_draw) begin
                in_draw = 1'b1;
                cap_n = note_out; cap_o = octave_out; cap_x = x; cap_y = y;
                cap_len = 1; cap_stable = 1;
            end else begin
                cap_len++;
                if (note_out != cap_n || octave_out != cap_o || x != cap_x || y != cap_y)
                    cap_stable = 0;
            end
        end else if (in_draw) begin
            in_draw = 1'b0;
            rec_note.push_back(cap_n); rec_oct.push_back(cap_o);
            rec_x.push_back(cap_x); rec_y.push_back(cap_y);
            rec_len.push_back(cap_len); rec_stable.push_back(cap_stable);
        end
        if (clear_prev && !clear_n) clr_falls++;
        clear_prev = clear_n;
    end

    // Expected draw for the next valid note: cell (idx%4, idx/4), 28 cells per screen.
    task automatic exp_add(input int n, input int o);
        exp_note.push_back(n); exp_oct.push_back(o);
        exp_x.push_back(2 + 40 * (cell_idx % 4));
        exp_y.push_back(2 + 16 * (cell_idx / 4));
        cell_idx = (cell_idx + 1) % 28;
    endtask

    task automatic push_ev(input logic [3:0] n, input logic [1:0] o);
        bit acc;
        int guard;
        note_in = n; octave_in = o; note_valid = 1'b1; guard = 0;
        do begin
            acc = note_ready;
            @(negedge clk);
            guard++;
        end while (!acc && guard < 30000);
        note_valid = 1'b0;
        if (!acc) check("push_timeout", 0, 1);
    endtask

    task automatic wait_draws(input int limit);
        int g;
        g = 0;
        while (rec_note.size() < exp_note.size() && g < limit) begin
            @(negedge clk);
            g++;
        end
        check("draw_count", rec_note.size(), exp_note.size());
        while (rec_note.size() > 0 && exp_note.size() > 0) begin
            check("draw_note", rec_note.pop_front(), exp_note.pop_front());
            check("draw_oct", rec_oct.pop_front(), exp_oct.pop_front());
            check("draw_x", rec_x.pop_front(), exp_x.pop_front());
            check("draw_y", rec_y.pop_front(), exp_y.pop_front());
            check("draw_len", rec_len.pop_front(), 432);
            check("draw_stable", rec_stable.pop_front(), 1);
        end
    endtask

    task automatic wait_ld_high();
        int g;
        g = 0;
        while (!ld_note && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("ld_start", int'(ld_note), 1);
    endtask

    task automatic measure_clear(output int lo, output int busy_bad);
        lo = 0; busy_bad = 0;
        while (!clear_n && lo < 25000) begin
            lo++;
            if (!busy) busy_bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, lo, bb, g, base;
        reset = 1'b1; note_in = 4'd0; octave_in = 2'd0;
        note_valid = 1'b0; clear_req = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_note", note_out, 0);
        check("rst_oct", octave_out, 0);
        check("rst_x", x, 2);
        check("rst_y", y, 2);
        check("rst_ld", ld_note, 0);
        check("rst_clear_n", clear_n, 0);
        check("rst_busy", busy, 1);
        check("rst_ready", note_ready, 1);

        // Power-up clear
        reset = 1'b0;
        measure_clear(lo, bb);
        check("pwrup_clear_len", lo, 19200);
        check("pwrup_busy_low", bb, 0);
        check("idle_busy", busy, 0);
        check("idle_x", x, 2);
        check("idle_y", y, 2);
        check("idle_ld", ld_note, 0);

        // Single note, latency 2 cycles, then next cell
        exp_add(5, 2);
        push_ev(4'd5, 2'd2);
        lat = 0;
        while (!ld_note && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("draw_latency", lat, 2);
        wait_draws(1000);
        check("hold_note", note_out, 5);
        check("hold_x", x, 2);
        exp_add(7, 1);
        push_ev(4'd7, 2'd1);
        wait_draws(1000);

        // Five notes back-to-back while a draw is running
        exp_add(1, 0);
        push_ev(4'd1, 2'd0);
        wait_ld_high();
        exp_add(2, 1); push_ev(4'd2, 2'd1);
        exp_add(3, 2); push_ev(4'd3, 2'd2);
        exp_add(4, 3); push_ev(4'd4, 2'd3);
        exp_add(6, 0); push_ev(4'd6, 2'd0);
        check("ready_full", note_ready, 0);
        exp_add(11, 1); push_ev(4'd11, 2'd1);
        wait_draws(4000);

        // Invalid codes: handshake only, no draw, cursor unchanged
        push_ev(4'd0, 2'd1);
        push_ev(4'd14, 2'd2);
        repeat (20) @(negedge clk);
        check("invalid_no_draw", rec_note.size(), 0);
        check("invalid_idle", busy, 0);
        exp_add(12, 3);
        push_ev(4'd12, 2'd3);
        wait_draws(1000);

        // clear_req mid-draw; ignored clear_req during CLEAR; FIFO survives clear
        exp_add(9, 1);
        push_ev(4'd9, 2'd1);
        wait_ld_high();
        repeat (100) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        cell_idx = 0;
        exp_add(10, 2);
        g = 0;
        while (clear_n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        lo = 0; bb = 0;
        while (!clear_n && lo < 25000) begin
            lo++;
            if (!busy) bb++;
            clear_req  = (lo == 500);
            note_valid = (lo == 600);
            note_in    = 4'd10;
            octave_in  = 2'd2;
            @(negedge clk);
        end
        clear_req = 1'b0; note_valid = 1'b0;
        check("req_clear_len", lo, 19200);
        check("req_clear_busy", bb, 0);
        wait_draws(2000);
        repeat (3) @(negedge clk);
        check("post_clear_busy", busy, 0);
        check("post_clear_clear_n", clear_n, 1);

        // Fill the grid: 28 cells then wrap to (2,2)
        base = clr_falls;
        for (int i = 0; i < 28; i++) begin
            exp_add((i % 12) + 1, i % 4);
            push_ev(4'((i % 12) + 1), 2'(i % 4));
        end
        wait_draws(40000);
        check("autoclear_count", clr_falls - base, EXP_AUTO_CLR);

        // Reset in mid-draw with a full FIFO
        push_ev(4'd8, 2'd0);
        wait_ld_high();
        for (int i = 0; i < 4; i++) push_ev(4'd3, 2'd1);
        check("pre_rst_ready", note_ready, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ld", ld_note, 0);
        check("midrst_clear_n", clear_n, 0);
        check("midrst_busy", busy, 1);
        check("midrst_ready", note_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_in_clear", clear_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
